// File: rtl/sel_mux_reg_pkg.sv
// Shared constants for the registered N:1 selection stage.
package sel_mux_reg_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/sel_mux_reg_rr_arbiter.sv
// Round-robin priority search: first requesting index scanning ptr, ptr+1, ... modulo N.
module rr_arbiter #(
   parameter int N    = 4,
   parameter int SELW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [SELW-1:0] gnt_idx,
   output logic            gnt_found
);

   int idx;

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!gnt_found && req[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = SELW'(idx);
         end
      end
   end

endmodule

// File: rtl/sel_mux_reg.sv
// Single-entry registered N:1 mux with direct-select and round-robin modes.
module sel_mux_reg
   import sel_mux_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SELW  = $clog2(N)
) (
   input  logic                 CLK,
   input  logic                 RESETN,
   input  logic [N*WIDTH-1:0]   IN_DATA,
   input  logic [N-1:0]         IN_VALID,
   output logic [N-1:0]         IN_READY,
   input  logic                 MODE,
   input  logic [SELW-1:0]      SELECT,
   output logic [WIDTH-1:0]     OUT_DATA,
   output logic [SELW-1:0]      OUT_SRC,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_src_q, out_src_d;
   logic             out_valid_q, out_valid_d;
   logic [SELW-1:0]  ptr_q, ptr_d;

   logic [SELW-1:0]  rr_idx, gnt_idx;
   logic             rr_found, direct_found, gnt_found;
   logic             load, xfer;
   logic [N-1:0]     in_ready;
   logic [WIDTH-1:0] gnt_data;

   rr_arbiter #(.N(N), .SELW(SELW)) u_rr_arbiter (
      .req       (IN_VALID),
      .ptr       (ptr_q),
      .gnt_idx   (rr_idx),
      .gnt_found (rr_found)
   );

   always_comb begin
      load = !out_valid_q | OUT_READY;

      // An out-of-range SELECT matches no source, so it simply never grants.
      direct_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (SELECT == SELW'(i) && IN_VALID[i]) direct_found = 1'b1;
      end

      if (MODE == MODE_RR) begin
         gnt_idx   = rr_idx;
         gnt_found = rr_found;
      end else begin
         gnt_idx   = SELECT;
         gnt_found = direct_found;
      end

      in_ready = '0;
      gnt_data = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_idx == SELW'(i)) begin
            gnt_data    = IN_DATA[i*WIDTH +: WIDTH];
            in_ready[i] = RESETN & load & gnt_found;
         end
      end
      xfer = |in_ready;

      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_data_d  = gnt_data;
         out_src_d   = gnt_idx;
         out_valid_d = 1'b1;
         if (MODE == MODE_RR) begin
            ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
         end
      end else if (load) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         out_data_q  <= '0;
         out_src_q   <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign IN_READY  = in_ready;
   assign OUT_DATA  = out_data_q;
   assign OUT_SRC   = out_src_q;
   assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_sel_mux_reg.sv
// Randomized and directed checks of sel_mux_reg against a behavioural model.
module tb_sel_mux_reg;
   import sel_mux_reg_pkg::*;

   localparam int WIDTH = 8;
   localparam int N     = 4;
   localparam int SELW  = 3;

   logic                 CLK = 1'b0;
   logic                 RESETN;
   logic [N*WIDTH-1:0]   IN_DATA;
   logic [N-1:0]         IN_VALID;
   logic [N-1:0]         IN_READY;
   logic                 MODE;
   logic [SELW-1:0]      SELECT;
   logic [WIDTH-1:0]     OUT_DATA;
   logic [SELW-1:0]      OUT_SRC;
   logic                 OUT_VALID;
   logic                 OUT_READY;

   int n_checks = 0;
   int n_fails  = 0;

   // behavioural model state
   bit m_valid;
   int m_data, m_src, m_ptr;
   int exp_ready, exp_g;

   sel_mux_reg #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
      .CLK       (CLK),
      .RESETN    (RESETN),
      .IN_DATA   (IN_DATA),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .MODE      (MODE),
      .SELECT    (SELECT),
      .OUT_DATA  (OUT_DATA),
      .OUT_SRC   (OUT_SRC),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int src_data(input int i);
      logic [N*WIDTH-1:0] d;
      d = IN_DATA;
      return int'(d[i*WIDTH +: WIDTH]);
   endfunction

   // One clock: check IN_READY against the model, clock, then check the register.
   task automatic step();
      bit load;
      #1;
      exp_g = -1;
      load  = !m_valid || OUT_READY;
      if (MODE == MODE_DIRECT) begin
         if (int'(SELECT) < N && IN_VALID[SELECT]) exp_g = int'(SELECT);
      end else begin
         for (int k = 0; k < N; k++) begin
            if (exp_g < 0 && IN_VALID[(m_ptr + k) % N]) exp_g = (m_ptr + k) % N;
         end
      end
      exp_ready = (RESETN && load && exp_g >= 0) ? (1 << exp_g) : 0;
      chk("in_ready", int'(IN_READY), exp_ready);
      @(posedge CLK);
      if (!RESETN) begin
         m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
      end else if (exp_ready != 0) begin
         m_valid = 1;
         m_data  = src_data(exp_g);
         m_src   = exp_g;
         if (MODE == MODE_RR) m_ptr = (exp_g + 1) % N;
      end else if (load) begin
         m_valid = 0;
      end
      @(negedge CLK);
      chk("out_valid", int'(OUT_VALID), int'(m_valid));
      chk("out_data", int'(OUT_DATA), m_data);
      chk("out_src", int'(OUT_SRC), m_src);
   endtask

   task automatic set_data(input int d0, input int d1, input int d2, input int d3);
      IN_DATA = {WIDTH'(d3), WIDTH'(d2), WIDTH'(d1), WIDTH'(d0)};
   endtask

   initial begin
      m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
      RESETN = 1'b0; IN_VALID = 4'b1111; MODE = MODE_RR; SELECT = '0; OUT_READY = 1'b1;
      set_data(8'h10, 8'h11, 8'h12, 8'h13);
      @(negedge CLK);
      step(); step();
      chk("rst_in_ready", int'(IN_READY), 0);
      chk("rst_out_valid", int'(OUT_VALID), 0);
      chk("rst_out_data", int'(OUT_DATA), 0);

      // direct select of source 2
      RESETN = 1'b1; MODE = MODE_DIRECT; SELECT = 3'd2;
      set_data(8'h01, 8'h02, 8'hA5, 8'h04);
      #1 chk("direct_ready", int'(IN_READY), 4'b0100);
      step();
      chk("direct_data", int'(OUT_DATA), 8'hA5);
      chk("direct_src", int'(OUT_SRC), 2);

      // round-robin, all valid: expect 0,1,2,3,0,1 back to back
      MODE = MODE_RR; set_data(8'h10, 8'h11, 8'h12, 8'h13);
      for (int c = 0; c < 6; c++) begin
         step();
         chk("rr_seq_src", int'(OUT_SRC), c % N);
         chk("rr_seq_valid", int'(OUT_VALID), 1);
      end

      // ptr is now 2; sources 1 and 3 valid -> 3, 1, 3
      IN_VALID = 4'b1010;
      step(); chk("rr_sparse_a", int'(OUT_SRC), 3);
      step(); chk("rr_sparse_b", int'(OUT_SRC), 1);
      step(); chk("rr_sparse_c", int'(OUT_SRC), 3);

      // stall for 3 cycles, then release with a same-cycle load
      IN_VALID = 4'b1111; OUT_READY = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("stall_src", int'(OUT_SRC), 3);
         chk("stall_ready", int'(IN_READY), 0);
      end
      OUT_READY = 1'b1;
      #1 chk("release_ready", int'(IN_READY), 4'b0001);
      step();
      chk("release_src", int'(OUT_SRC), 0);

      // out-of-range select never grants
      MODE = MODE_DIRECT; SELECT = 3'd5;
      step();
      chk("sel5_valid", int'(OUT_VALID), 0);
      chk("sel5_hold_src", int'(OUT_SRC), 0);

      // reset during a stall discards the word
      SELECT = 3'd1; step();
      OUT_READY = 1'b0; step();
      RESETN = 1'b0; step();
      chk("rst_stall_valid", int'(OUT_VALID), 0);
      RESETN = 1'b1; OUT_READY = 1'b1; MODE = MODE_RR; IN_VALID = 4'b1111;
      step();
      chk("rst_rr_first", int'(OUT_SRC), 0);

      for (int c = 0; c < 400; c++) begin
         RESETN    = ($urandom_range(0, 39) != 0);
         MODE      = 1'($urandom_range(0, 1));
         SELECT    = SELW'($urandom_range(0, 5));
         IN_VALID  = N'($urandom);
         IN_DATA   = (N*WIDTH)'($urandom);
         OUT_READY = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/sel_mux_reg.md
SEL_MUX_REG -- requirements
Module: sel_mux_reg

Interface
REQ-001 Parameter WIDTH, default 8: data width of each source and of the output, in bits.
REQ-002 Parameter N, default 4: number of sources, N >= 2.
REQ-003 Parameter SELW, default $clog2(N): width of select and source-ID fields.
REQ-004 CLK  input  1  the only clock; all state updates on its rising edge.
REQ-005 RESETN  input  1  synchronous, active-low reset, sampled on the rising edge of CLK.
REQ-006 IN_DATA  input  N*WIDTH  source data; source i occupies bits [i*WIDTH +: WIDTH].
REQ-007 IN_VALID  input  N  per-source valid.
REQ-008 IN_READY  output  N  per-source accept, one-hot or zero.
REQ-009 MODE  input  1  selection mode: 0 = direct (SELECT), 1 = round-robin.
REQ-010 SELECT  input  SELW  source index used in direct mode.
REQ-011 OUT_DATA  output  WIDTH  registered selected data.
REQ-012 OUT_SRC  output  SELW  index of the source that supplied OUT_DATA.
REQ-013 OUT_VALID  output  1  OUT_DATA/OUT_SRC hold a valid word.
REQ-014 OUT_READY  input  1  consumer accepts the word this cycle when OUT_VALID=1.

Function
REQ-015 The block SHALL be a single-entry registered N:1 mux stage; LOAD = !OUT_VALID | OUT_READY.
REQ-016 Direct mode: the candidate SHALL be SELECT; a grant occurs only if SELECT < N and IN_VALID[SELECT]=1.
REQ-017 Direct mode, SELECT >= N: there SHALL be no grant, IN_READY = 0, and the stage SHALL behave as if no source is valid.
REQ-018 Round-robin mode: the grant SHALL go to the first i with IN_VALID[i]=1, scanning PTR, PTR+1, ... modulo N.
REQ-019 IN_READY[g] SHALL be 1 only when g is granted and LOAD=1; all other bits SHALL be 0; IN_READY is combinational from the inputs and state.
REQ-020 On a transfer (IN_VALID[g] & IN_READY[g]): OUT_DATA <= source g data, OUT_SRC <= g, OUT_VALID <= 1 at the next edge; latency SHALL be exactly 1 cycle.
REQ-021 If LOAD=1 and there is no grant, OUT_VALID SHALL go to 0 at the next edge and OUT_DATA/OUT_SRC SHALL hold their values.
REQ-022 Stall (OUT_VALID=1, OUT_READY=0): OUT_DATA, OUT_SRC and OUT_VALID SHALL stay stable, and IN_READY SHALL be 0.
REQ-023 Throughput SHALL be one word per cycle when OUT_READY is held high.
REQ-024 PTR (SELW bits) SHALL update to (g+1) mod N on every round-robin transfer, wrapping from N-1 to 0.
REQ-025 PTR SHALL NOT change on direct-mode transfers or on cycles without a transfer.
REQ-026 A MODE or SELECT change SHALL take effect in the same cycle's grant; a word already in the register SHALL be unaffected.
REQ-027 Simultaneous drain and load (OUT_VALID=1, OUT_READY=1, grant): the new word SHALL replace the old one with no bubble.
REQ-028 Data SHALL pass through unmodified; there is no arithmetic on data.

Reset
REQ-029 When RESETN=0 at a rising edge: OUT_VALID <= 0, OUT_DATA <= 0, OUT_SRC <= 0, PTR <= 0.
REQ-030 While RESETN=0, IN_READY SHALL be 0.
REQ-031 Reset mid-stall SHALL discard the held word, and no transfer SHALL be counted in that cycle.
REQ-032 The first grant after reset in round-robin mode SHALL start the scan at source 0.

Structure
REQ-033 The shared package SHALL hold the MODE_DIRECT=1'b0 and MODE_RR=1'b1 constants.
REQ-034 The round-robin priority search SHALL be a sub-module rr_arbiter (inputs: request vector and PTR; outputs: grant index and grant-found flag), parametrised by N.
REQ-035 The top level SHALL contain the output register, the PTR register, the mode selection and the IN_READY decode.

Verification
REQ-036 Reset: RESETN=0 for 2 cycles with all IN_VALID=1 -> OUT_VALID=0, OUT_DATA=0x00, OUT_SRC=0, IN_READY=0000.
REQ-037 Direct mode, N=4, SELECT=2, IN_DATA[2]=0xA5, IN_VALID=1111, OUT_READY=1 -> IN_READY=0100; next cycle OUT_DATA=0xA5, OUT_SRC=2, OUT_VALID=1.
REQ-038 Round-robin mode, all sources valid, data 0x10/0x11/0x12/0x13, OUT_READY=1 for 6 cycles -> OUT_SRC sequence 0,1,2,3,0,1 with no bubbles (PTR wrap).
REQ-039 Round-robin mode, IN_VALID=1010, PTR=2 -> grant 3, then 1, then 3; sources 0 and 2 never get IN_READY.
REQ-040 Stall: OUT_READY=0 for 3 cycles while OUT_VALID=1 -> OUT_DATA/OUT_SRC constant and IN_READY=0000; on OUT_READY=1, the next word loads in the same cycle.
REQ-041 Direct mode, SELECT=5 with N=4 (SELW=3 override), or RESETN=0 during a stall -> no grant, OUT_VALID drops to 0 at the next edge.
